grid_to_pixel: RTL and testbench

Converts Tetris playfield grid positions (column 0–9, row 0–19) back into screen pixel coordinates. It is the inverse of the pixel-to-grid position decoder: every coordinate this block emits decodes back to the same cell. The block serves single cell lookups over a valid/ready handshake. It also offers a sweep mode that walks all 200 cells in row-major order, which the renderer and the line-clear logic use to redraw the board.

---
 rtl/tetris_grid_pkg.sv | 40 ++++
 rtl/cell_origin_calc.sv | 41 ++++
 rtl/grid_to_pixel.sv | 226 ++++++++++++++++++++++
 tb/tb_grid_to_pixel.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_grid_pkg.sv
// -----------------------------------------------------------------------------
// tetris_grid_pkg
// Shared playfield geometry for the pixel<->grid converters. Both the
// pixel-to-grid decoder and grid_to_pixel take their constants from here so
// the two directions always agree on cell pitch and board origin.
// Contents:
//   GRID_COLS, GRID_ROWS, CELL_PX, ORIGIN_X, ROW_REF_Y - board geometry
//   cell_idx_t  - 5-bit column/row index
//   state_e     - grid_to_pixel sweep FSM state
//   cell_offset - CELL_PX * n, shift-add form for the 20 px pitch
// -----------------------------------------------------------------------------
package tetris_grid_pkg;

    localparam int GRID_COLS = 10;
    localparam int GRID_ROWS = 20;
    localparam int CELL_PX   = 20;
    localparam int ORIGIN_X  = 240;
    localparam int ROW_REF_Y = 60;

    typedef logic [4:0] cell_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Pixel offset of cell n; the 20 px pitch uses 16n + 4n so no multiplier
    // is built for the standard board.
    function automatic logic [9:0] cell_offset(input cell_idx_t n, input int px);
        logic [9:0] n_w;
        n_w = {5'd0, n};
        if (px == 20) begin
            cell_offset = (n_w << 3'd4) + (n_w << 3'd2);
        end else begin
            cell_offset = 10'(n_w * 10'(px));
        end
    endfunction

endpackage

// File: rtl/cell_origin_calc.sv
// -----------------------------------------------------------------------------
// cell_origin_calc
// Combinational (col,row) -> (x,y,err) mapper shared by the single-lookup and
// sweep paths of grid_to_pixel. Out-of-range cells report err=1 with x=y=0.
// Ports:
//   col, row : in  5-bit cell position
//   x, y     : out 10-bit pixel coordinate of the cell origin
//   err      : out cell lies outside the playfield
// -----------------------------------------------------------------------------
module cell_origin_calc #(
    parameter int GRID_COLS = tetris_grid_pkg::GRID_COLS,
    parameter int GRID_ROWS = tetris_grid_pkg::GRID_ROWS,
    parameter int CELL_PX   = tetris_grid_pkg::CELL_PX,
    parameter int ORIGIN_X  = tetris_grid_pkg::ORIGIN_X,
    parameter int ROW_REF_Y = tetris_grid_pkg::ROW_REF_Y
) (
    input  logic [4:0] col,
    input  logic [4:0] row,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       err
);
    import tetris_grid_pkg::*;

    localparam cell_idx_t COL_LIM = cell_idx_t'(GRID_COLS);
    localparam cell_idx_t ROW_LIM = cell_idx_t'(GRID_ROWS);

    // Range check and origin arithmetic; the sums stay within 10 bits for
    // every in-range cell of the default board.
    always_comb begin
        err = (col >= COL_LIM) || (row >= ROW_LIM);
        if (err) begin
            x = 10'd0;
            y = 10'd0;
        end else begin
            x = 10'(ORIGIN_X)  + cell_offset(col, CELL_PX);
            y = 10'(ROW_REF_Y) + cell_offset(row, CELL_PX);
        end
    end

endmodule

// File: rtl/grid_to_pixel.sv
// -----------------------------------------------------------------------------
// grid_to_pixel
// Converts playfield cells to screen pixel coordinates: single lookups over a
// valid/ready handshake, plus an optional row-major sweep of the whole board.
// Optional feature macro: GRID_TO_PIXEL_SWEEP_EN (sweep mode present when
// defined; otherwise sweep_start is ignored and busy/rsp_last are 0).
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : single lookup handshake, req_col/req_row cell
//   sweep_start, busy     : start full-board sweep / sweep in progress
//   rsp_valid/rsp_ready   : response handshake
//   rsp_x, rsp_y          : pixel coordinate, rsp_col/rsp_row echo the cell
//   rsp_err, rsp_last     : out-of-range request / final cell of a sweep
// -----------------------------------------------------------------------------
module grid_to_pixel #(
    parameter int GRID_COLS = tetris_grid_pkg::GRID_COLS,
    parameter int GRID_ROWS = tetris_grid_pkg::GRID_ROWS,
    parameter int CELL_PX   = tetris_grid_pkg::CELL_PX,
    parameter int ORIGIN_X  = tetris_grid_pkg::ORIGIN_X,
    parameter int ROW_REF_Y = tetris_grid_pkg::ROW_REF_Y
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [4:0] req_col,
    input  logic [4:0] req_row,
    input  logic       sweep_start,
    output logic       busy,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [9:0] rsp_x,
    output logic [9:0] rsp_y,
    output logic [4:0] rsp_col,
    output logic [4:0] rsp_row,
    output logic       rsp_err,
    output logic       rsp_last
);
    import tetris_grid_pkg::*;

    logic       rsp_valid_q, rsp_valid_d;
    logic [9:0] rsp_x_q, rsp_x_d;
    logic [9:0] rsp_y_q, rsp_y_d;
    cell_idx_t  rsp_col_q, rsp_col_d;
    cell_idx_t  rsp_row_q, rsp_row_d;
    logic       rsp_err_q, rsp_err_d;
    logic       rsp_last_q, rsp_last_d;

    logic       rsp_free_s;
    logic       req_ready_s;
    logic       sweep_load_s;
    logic       load_last_s;
    logic       load_s;
    cell_idx_t  calc_col_s, calc_row_s;
    logic [9:0] calc_x_s, calc_y_s;
    logic       calc_err_s;

    // The response register can take new data when empty or being drained.
    assign rsp_free_s = !rsp_valid_q || rsp_ready;

`ifdef GRID_TO_PIXEL_SWEEP_EN
    localparam cell_idx_t LAST_COL = cell_idx_t'(GRID_COLS - 1);
    localparam cell_idx_t LAST_ROW = cell_idx_t'(GRID_ROWS - 1);

    state_e    state_q, state_d;
    cell_idx_t cnt_col_q, cnt_col_d;
    cell_idx_t cnt_row_q, cnt_row_d;
    logic      sweep_at_last_s;

    assign sweep_at_last_s = (cnt_col_q == LAST_COL) && (cnt_row_q == LAST_ROW);

    // Sweep FSM: a cell is emitted whenever the response register frees up,
    // so the counter always points at the next cell still to be sent.
    always_comb begin
        state_d      = state_q;
        cnt_col_d    = cnt_col_q;
        cnt_row_d    = cnt_row_q;
        sweep_load_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sweep_start) begin
                    state_d   = ST_SWEEP;
                    cnt_col_d = 5'd0;
                    cnt_row_d = 5'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (rsp_free_s) begin
                    sweep_load_s = 1'b1;
                    if (sweep_at_last_s) begin
                        state_d   = ST_DRAIN;
                        cnt_col_d = 5'd0;
                        cnt_row_d = 5'd0;
                    end else if (cnt_col_q == LAST_COL) begin
                        cnt_col_d = 5'd0;
                        cnt_row_d = cnt_row_q + 5'd1;
                    end else begin
                        cnt_col_d = cnt_col_q + 5'd1;
                    end
                end else begin
                    sweep_load_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_col_d = 5'd0;
                cnt_row_d = 5'd0;
            end
        endcase
    end

    // Sweep state and cell counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_col_q <= 5'd0;
            cnt_row_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            cnt_col_q <= cnt_col_d;
            cnt_row_q <= cnt_row_d;
        end
    end

    // sweep_start has priority over a simultaneous single request.
    assign req_ready_s = (state_q == ST_IDLE) && rsp_free_s && !sweep_start;
    assign busy        = (state_q != ST_IDLE);
    assign load_last_s = sweep_load_s && sweep_at_last_s;
    assign calc_col_s  = (state_q == ST_SWEEP) ? cnt_col_q : req_col;
    assign calc_row_s  = (state_q == ST_SWEEP) ? cnt_row_q : req_row;
`else
    logic unused_sweep_start_s;

    assign unused_sweep_start_s = sweep_start;
    assign req_ready_s          = rsp_free_s;
    assign busy                 = 1'b0;
    assign sweep_load_s         = 1'b0;
    assign load_last_s          = 1'b0;
    assign calc_col_s           = req_col;
    assign calc_row_s           = req_row;
`endif

    assign load_s = (req_valid && req_ready_s) || sweep_load_s;

    cell_origin_calc #(
        .GRID_COLS (GRID_COLS),
        .GRID_ROWS (GRID_ROWS),
        .CELL_PX   (CELL_PX),
        .ORIGIN_X  (ORIGIN_X),
        .ROW_REF_Y (ROW_REF_Y)
    ) u_calc (
        .col (calc_col_s),
        .row (calc_row_s),
        .x   (calc_x_s),
        .y   (calc_y_s),
        .err (calc_err_s)
    );

    // Response register: cleared on handoff, reloaded when a new cell is taken.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_x_d     = rsp_x_q;
        rsp_y_d     = rsp_y_q;
        rsp_col_d   = rsp_col_q;
        rsp_row_d   = rsp_row_q;
        rsp_err_d   = rsp_err_q;
        rsp_last_d  = rsp_last_q;
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
            rsp_last_d  = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
        if (load_s) begin
            rsp_valid_d = 1'b1;
            rsp_x_d     = calc_x_s;
            rsp_y_d     = calc_y_s;
            rsp_col_d   = calc_col_s;
            rsp_row_d   = calc_row_s;
            rsp_err_d   = calc_err_s;
            rsp_last_d  = load_last_s;
        end else begin
            rsp_x_d = rsp_x_q;
        end
    end

    // Response output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_x_q     <= 10'd0;
            rsp_y_q     <= 10'd0;
            rsp_col_q   <= 5'd0;
            rsp_row_q   <= 5'd0;
            rsp_err_q   <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_x_q     <= rsp_x_d;
            rsp_y_q     <= rsp_y_d;
            rsp_col_q   <= rsp_col_d;
            rsp_row_q   <= rsp_row_d;
            rsp_err_q   <= rsp_err_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_x     = rsp_x_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_col   = rsp_col_q;
    assign rsp_row   = rsp_row_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_grid_to_pixel.sv
// -----------------------------------------------------------------------------
// tb_grid_to_pixel
// Directed self-checking bench for grid_to_pixel. Sweep scenarios are built
// only when GRID_TO_PIXEL_SWEEP_EN is defined; otherwise the bench checks that
// sweep_start has no effect.
// -----------------------------------------------------------------------------
module tb_grid_to_pixel;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_col;
    logic [4:0] req_row;
    logic       sweep_start;
    logic       busy;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [9:0] rsp_x;
    logic [9:0] rsp_y;
    logic [4:0] rsp_col;
    logic [4:0] rsp_row;
    logic       rsp_err;
    logic       rsp_last;

    int n_checks = 0;
    int n_pass   = 0;

    grid_to_pixel dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_col     (req_col),
        .req_row     (req_row),
        .sweep_start (sweep_start),
        .busy        (busy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_x       (rsp_x),
        .rsp_y       (rsp_y),
        .rsp_col     (rsp_col),
        .rsp_row     (rsp_row),
        .rsp_err     (rsp_err),
        .rsp_last    (rsp_last)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [9:0] x, input logic [9:0] y,
                             input logic [4:0] c, input logic [4:0] r, input logic e);
        check_eq({tag, " valid"}, rsp_valid, 1);
        check_eq({tag, " x"}, rsp_x, x);
        check_eq({tag, " y"}, rsp_y, y);
        check_eq({tag, " col"}, rsp_col, c);
        check_eq({tag, " row"}, rsp_row, r);
        check_eq({tag, " err"}, rsp_err, e);
        check_eq({tag, " last"}, rsp_last, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " req_ready"}, req_ready, 1);
        check_eq({tag, " busy"}, busy, 0);
        check_eq({tag, " rsp_valid"}, rsp_valid, 0);
        check_eq({tag, " rsp_err"}, rsp_err, 0);
        check_eq({tag, " rsp_last"}, rsp_last, 0);
        check_eq({tag, " rsp_x"}, rsp_x, 0);
        check_eq({tag, " rsp_y"}, rsp_y, 0);
        check_eq({tag, " rsp_col"}, rsp_col, 0);
        check_eq({tag, " rsp_row"}, rsp_row, 0);
    endtask

    // One accepted lookup with rsp_ready high; checks 1-cycle latency.
    task automatic lookup(input logic [4:0] c, input logic [4:0] r);
        req_valid = 1'b1;
        req_col   = c;
        req_row   = r;
        #1;
        check_eq("lookup req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_col     = 5'd0;
        req_row     = 5'd0;
        sweep_start = 1'b0;
        rsp_ready   = 1'b1;
        repeat (2) tick();
        check_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // Corner cells
        lookup(5'd0, 5'd0);
        check_rsp("c00", 10'd240, 10'd60, 5'd0, 5'd0, 1'b0);
        lookup(5'd9, 5'd19);
        check_rsp("c919", 10'd420, 10'd440, 5'd9, 5'd19, 1'b0);
        tick();
        check_eq("drained valid", rsp_valid, 0);

        // Out of range
        lookup(5'd10, 5'd5);
        check_rsp("oor col", 10'd0, 10'd0, 5'd10, 5'd5, 1'b1);
        lookup(5'd3, 5'd20);
        check_rsp("oor row", 10'd0, 10'd0, 5'd3, 5'd20, 1'b1);

        // Back-to-back throughput
        lookup(5'd1, 5'd0);
        check_rsp("b2b 1", 10'd260, 10'd60, 5'd1, 5'd0, 1'b0);
        lookup(5'd2, 5'd0);
        check_rsp("b2b 2", 10'd280, 10'd60, 5'd2, 5'd0, 1'b0);
        tick();

        // Backpressure: response held, new request refused
        rsp_ready = 1'b0;
        lookup(5'd4, 5'd2);
        req_valid = 1'b1;
        req_col   = 5'd1;
        req_row   = 5'd1;
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp hold", 10'd320, 10'd100, 5'd4, 5'd2, 1'b0);
            check_eq("bp req_ready", req_ready, 0);
            tick();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        #1;
        check_eq("bp release req_ready", req_ready, 1);
        tick();
        check_eq("bp released", rsp_valid, 0);

        // Reset while a response is pending
        rsp_ready = 1'b0;
        lookup(5'd5, 5'd5);
        check_rsp("pend", 10'd340, 10'd160, 5'd5, 5'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid reset");
        rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef GRID_TO_PIXEL_SWEEP_EN
        // Collision: sweep_start wins over a simultaneous request
        sweep_start = 1'b1;
        req_valid   = 1'b1;
        req_col     = 5'd2;
        req_row     = 5'd2;
        #1;
        check_eq("coll req_ready", req_ready, 0);
        tick();
        sweep_start = 1'b0;
        check_eq("sweep busy", busy, 1);
        check_eq("sweep first latency", rsp_valid, 0);
        for (int k = 0; k < 200; k++) begin
            tick();
            check_eq("sw valid", rsp_valid, 1);
            check_eq("sw col", rsp_col, k % 10);
            check_eq("sw row", rsp_row, k / 10);
            check_eq("sw x", rsp_x, 240 + 20 * (k % 10));
            check_eq("sw y", rsp_y, 60 + 20 * (k / 10));
            check_eq("sw err", rsp_err, 0);
            check_eq("sw last", rsp_last, (k == 199) ? 1 : 0);
            check_eq("sw dec col", (32'(rsp_x) - 240) / 20, k % 10);
            check_eq("sw dec row", (32'(rsp_y) - 60) / 20, k / 10);
            check_eq("sw req_ready", req_ready, 0);
            check_eq("sw busy", busy, 1);
        end
        tick();
        check_eq("sweep done busy", busy, 0);
        check_eq("sweep done valid", rsp_valid, 0);
        check_eq("held req ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        check_rsp("held req", 10'd280, 10'd100, 5'd2, 5'd2, 1'b0);
        tick();

        // Reset mid-sweep at (3,7), then restart from (0,0)
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (74) tick();
        check_eq("pre col", rsp_col, 3);
        check_eq("pre row", rsp_row, 7);
        rst_n = 1'b0;
        #1;
        check_reset_vals("sweep reset");
        tick();
        rst_n = 1'b1;
        tick();
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        check_eq("restart col", rsp_col, 0);
        check_eq("restart row", rsp_row, 0);
        check_eq("restart x", rsp_x, 240);
        check_eq("restart y", rsp_y, 60);
        repeat (202) tick();
        check_eq("restart end busy", busy, 0);
`else
        // Without sweep mode, sweep_start is ignored and requests proceed
        sweep_start = 1'b1;
        lookup(5'd2, 5'd2);
        sweep_start = 1'b0;
        check_rsp("nosweep req", 10'd280, 10'd100, 5'd2, 5'd2, 1'b0);
        check_eq("nosweep busy", busy, 0);
        tick();
        check_eq("nosweep idle", rsp_valid, 0);
        check_eq("nosweep busy2", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
